char_console_writer: RTL and testbench

CHAR_CONSOLE_WRITER -- requirements
Module: char_console_writer

---
 rtl/char_console_writer_if.sv | 40 ++++
 rtl/char_console_writer.sv | 257 +++++++++++++++++++++++++
 tb/tb_char_console_writer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_console_writer_if.sv
// ============================================================================
// Module      : char_console_writer_if
// Description : Character stream handshake, VRAM/config write bus and cursor
//               status for the character console writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface char_console_writer_if;
    logic        CH_VALID;
    logic        CH_READY;
    logic [7:0]  CH_DATA;
    logic [11:0] CH_COLOR;
    logic [1:0]  CH_ATTR;

    logic [15:0] WRITE_ADDR;
    logic [3:0]  BYTE_EN;
    logic        WRITE_EN;
    logic [31:0] WRITE_DATA;

    logic [6:0]  CUR_COL;
    logic [5:0]  CUR_ROW;
    logic [5:0]  SCROLL_OFS;

    // Character source / bus and status observer side
    modport master (
        output CH_VALID, CH_DATA, CH_COLOR, CH_ATTR,
        input  CH_READY, WRITE_ADDR, BYTE_EN, WRITE_EN, WRITE_DATA,
        input  CUR_COL, CUR_ROW, SCROLL_OFS
    );

    // Console writer side
    modport slave (
        input  CH_VALID, CH_DATA, CH_COLOR, CH_ATTR,
        output CH_READY, WRITE_ADDR, BYTE_EN, WRITE_EN, WRITE_DATA,
        output CUR_COL, CUR_ROW, SCROLL_OFS
    );
endinterface

`default_nettype wire

// File: rtl/char_console_writer.sv
// ============================================================================
// Module      : char_console_writer
// Description : Turns a character stream into VRAM entry writes on a ring of
//               text rows, with CR/LF/BS/FF handling and hardware scrolling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module char_console_writer #(
    parameter int          NUM_COLS  = 80,
    parameter int          NUM_ROWS  = 50,
    parameter logic [15:0] CONF_ADDR = 16'h4000
) (
    input wire              CLK,
    input wire              RST,
    char_console_writer_if.slave bus
);

    localparam int                 TOTAL       = NUM_COLS * NUM_ROWS;
    localparam int                 CNT_W       = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0]   C_CNT_COLS  = CNT_W'(NUM_COLS);
    localparam logic [CNT_W-1:0]   C_CNT_TOTAL = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0]   C_CNT_ONE   = CNT_W'(1);
    localparam logic [6:0]         C_LAST_COL  = 7'(NUM_COLS - 1);
    localparam logic [5:0]         C_LAST_ROW  = 6'(NUM_ROWS - 1);
    localparam logic [6:0]         C_ROWS_7    = 7'(NUM_ROWS);
    localparam logic [31:0]        C_BLANK     = 32'h0000_0020;
    localparam logic [3:0]         C_BE_ENTRY  = 4'b0111;
    localparam logic [3:0]         C_BE_CONF   = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_CHAR = 3'd1,
        S_WR_CONF = 3'd2,
        S_CLR_ROW = 3'd3,
        S_CLR_ALL = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       col_q, col_d;
    logic [5:0]       row_q, row_d;
    logic [5:0]       ofs_q, ofs_d;
    logic [5:0]       clr_row_q, clr_row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             conf_clr_q, conf_clr_d;
    logic             scroll_pend_q, scroll_pend_d;
    logic             ready_q, ready_d;
    logic             we_q, we_d;
    logic [15:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       be_q, be_d;

    logic        w_accept;
    logic        w_printable;
    logic [6:0]  w_sum;
    logic [5:0]  w_prow;
    logic [5:0]  w_ofs_inc;
    logic [15:0] w_char_addr;
    logic [15:0] w_clr_addr;
    logic [15:0] w_all_addr;
    logic [31:0] w_entry;

    assign w_accept    = bus.CH_VALID & ready_q;
    assign w_printable = (bus.CH_DATA >= 8'h20) && (bus.CH_DATA <= 8'h7E);
    assign w_sum       = {1'b0, ofs_q} + {1'b0, row_q};
    assign w_prow      = (w_sum >= C_ROWS_7) ? 6'(w_sum - C_ROWS_7) : w_sum[5:0];
    assign w_ofs_inc   = (ofs_q == C_LAST_ROW) ? 6'd0 : ofs_q + 6'd1;
    assign w_char_addr = (16'(w_prow) * 16'(NUM_COLS) + 16'(col_q)) << 2;
    assign w_clr_addr  = (16'(clr_row_q) * 16'(NUM_COLS) + 16'(cnt_q)) << 2;
    assign w_all_addr  = 16'(cnt_q) << 2;
    assign w_entry     = {8'h00, 2'b00, bus.CH_ATTR, bus.CH_COLOR, 1'b0, bus.CH_DATA[6:0]};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            col_q         <= 7'd0;
            row_q         <= 6'd0;
            ofs_q         <= 6'd0;
            clr_row_q     <= 6'd0;
            cnt_q         <= '0;
            conf_clr_q    <= 1'b0;
            scroll_pend_q <= 1'b0;
            ready_q       <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= 16'd0;
            data_q        <= 32'd0;
            be_q          <= 4'd0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            ofs_q         <= ofs_d;
            clr_row_q     <= clr_row_d;
            cnt_q         <= cnt_d;
            conf_clr_q    <= conf_clr_d;
            scroll_pend_q <= scroll_pend_d;
            ready_q       <= ready_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            be_q          <= be_d;
        end
    end

    // The *_d bus values describe the write that appears on the bus next cycle.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        ofs_d         = ofs_q;
        clr_row_d     = clr_row_q;
        cnt_d         = cnt_q;
        conf_clr_d    = conf_clr_q;
        scroll_pend_d = scroll_pend_q;
        we_d          = 1'b0;
        addr_d        = 16'd0;
        data_d        = 32'd0;
        be_d          = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_printable) begin
                        we_d    = 1'b1;
                        addr_d  = w_char_addr;
                        data_d  = w_entry;
                        be_d    = C_BE_ENTRY;
                        state_d = S_WR_CHAR;
                        if (col_q == C_LAST_COL) begin
                            col_d = 7'd0;
                            if (row_q == C_LAST_ROW) begin
                                scroll_pend_d = 1'b1;
                                ofs_d         = w_ofs_inc;
                                clr_row_d     = ofs_q;
                            end else begin
                                row_d = row_q + 6'd1;
                            end
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (bus.CH_DATA)
                            8'h0D: col_d = 7'd0;
                            8'h08: begin
                                if (col_q != 7'd0) col_d = col_q - 7'd1;
                            end
                            8'h0A: begin
                                col_d = 7'd0;
                                if (row_q == C_LAST_ROW) begin
                                    ofs_d      = w_ofs_inc;
                                    clr_row_d  = ofs_q;
                                    we_d       = 1'b1;
                                    addr_d     = CONF_ADDR;
                                    data_d     = {26'd0, w_ofs_inc};
                                    be_d       = C_BE_CONF;
                                    conf_clr_d = 1'b1;
                                    cnt_d      = '0;
                                    state_d    = S_WR_CONF;
                                end else begin
                                    row_d = row_q + 6'd1;
                                end
                            end
                            8'h0C: begin
                                col_d   = 7'd0;
                                row_d   = 6'd0;
                                ofs_d   = 6'd0;
                                we_d    = 1'b1;
                                addr_d  = 16'd0;
                                data_d  = C_BLANK;
                                be_d    = C_BE_ENTRY;
                                cnt_d   = C_CNT_ONE;
                                state_d = S_CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            S_WR_CHAR: begin
                if (scroll_pend_q) begin
                    scroll_pend_d = 1'b0;
                    we_d          = 1'b1;
                    addr_d        = CONF_ADDR;
                    data_d        = {26'd0, ofs_q};
                    be_d          = C_BE_CONF;
                    conf_clr_d    = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_WR_CONF;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WR_CONF: begin
                if (conf_clr_q) begin
                    conf_clr_d = 1'b0;
                    we_d       = 1'b1;
                    addr_d     = w_clr_addr;
                    data_d     = C_BLANK;
                    be_d       = C_BE_ENTRY;
                    cnt_d      = cnt_q + C_CNT_ONE;
                    state_d    = S_CLR_ROW;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CLR_ROW: begin
                if (cnt_q < C_CNT_COLS) begin
                    we_d   = 1'b1;
                    addr_d = w_clr_addr;
                    data_d = C_BLANK;
                    be_d   = C_BE_ENTRY;
                    cnt_d  = cnt_q + C_CNT_ONE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CLR_ALL: begin
                if (cnt_q < C_CNT_TOTAL) begin
                    we_d   = 1'b1;
                    addr_d = w_all_addr;
                    data_d = C_BLANK;
                    be_d   = C_BE_ENTRY;
                    cnt_d  = cnt_q + C_CNT_ONE;
                end else begin
                    // Screen is blank: publish offset 0, then return to idle.
                    we_d       = 1'b1;
                    addr_d     = CONF_ADDR;
                    data_d     = 32'd0;
                    be_d       = C_BE_CONF;
                    conf_clr_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_WR_CONF;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign ready_d = (state_d == S_IDLE);

    assign bus.CH_READY   = ready_q;
    assign bus.WRITE_EN   = we_q;
    assign bus.WRITE_ADDR = addr_q;
    assign bus.WRITE_DATA = data_q;
    assign bus.BYTE_EN    = be_q;
    assign bus.CUR_COL    = col_q;
    assign bus.CUR_ROW    = row_q;
    assign bus.SCROLL_OFS = ofs_q;

endmodule

`default_nettype wire

// File: tb/tb_char_console_writer.sv
// ============================================================================
// Module      : tb_char_console_writer
// Description : Directed self-checking bench for char_console_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_char_console_writer;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    char_console_writer_if bus ();

    char_console_writer #(
        .NUM_COLS (80),
        .NUM_ROWS (50),
        .CONF_ADDR(16'h4000)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          q_cyc[$];
    logic [15:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_be[$];
    int          idle_viol = 0;

    // Bus recorder; also flags non-zero bus fields while the strobe is low.
    always @(negedge CLK) begin
        if (bus.WRITE_EN === 1'b1) begin
            q_cyc.push_back(cyc);
            q_addr.push_back(bus.WRITE_ADDR);
            q_data.push_back(bus.WRITE_DATA);
            q_be.push_back(bus.BYTE_EN);
        end else if (bus.WRITE_ADDR !== 16'd0 || bus.WRITE_DATA !== 32'd0 || bus.BYTE_EN !== 4'd0) begin
            idle_viol++;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qa(int i);
        return (i < q_addr.size()) ? 32'(q_addr[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] qd(int i);
        return (i < q_data.size()) ? q_data[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] qb(int i);
        return (i < q_be.size()) ? 32'(q_be[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic int qc(int i);
        return (i < q_cyc.size()) ? q_cyc[i] : -1;
    endfunction

    task automatic clear_q();
        q_cyc.delete();
        q_addr.delete();
        q_data.delete();
        q_be.delete();
    endtask

    // Called at a negedge; returns the cycle at which CH_READY is seen high.
    task automatic wait_ready(output int rc);
        int t = 0;
        while (bus.CH_READY !== 1'b1 && t < 6000) begin
            @(negedge CLK);
            t++;
        end
        rc = cyc;
        if (t >= 6000) chk("ready_timeout", 32'(bus.CH_READY), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic [11:0] c, input logic [1:0] a, output int n);
        int rc;
        wait_ready(rc);
        clear_q();
        bus.CH_VALID = 1'b1;
        bus.CH_DATA  = d;
        bus.CH_COLOR = c;
        bus.CH_ATTR  = a;
        n = cyc;
        @(negedge CLK);
        bus.CH_VALID = 1'b0;
    endtask

    task automatic check_clear_run(input string tag, input int first, input int cnt,
                                   input logic [15:0] base, input int cyc0);
        int errs = 0;
        for (int i = 0; i < cnt; i++) begin
            if (qa(first + i) !== 32'(base) + 32'(4 * i) || qd(first + i) !== 32'h20 ||
                qb(first + i) !== 32'h7 || qc(first + i) != cyc0 + i)
                errs++;
        end
        chk(tag, 32'(errs), 32'd0);
    endtask

    task automatic check_ctrl(input string tag, input int n, input logic [6:0] col, input logic [5:0] row);
        int rc;
        wait_ready(rc);
        chk({tag, "_ready"}, 32'(rc), 32'(n + 1));
        chk({tag, "_nwr"}, 32'(q_addr.size()), 32'd0);
        chk({tag, "_col"}, 32'(bus.CUR_COL), 32'(col));
        chk({tag, "_row"}, 32'(bus.CUR_ROW), 32'(row));
    endtask

    initial begin
        int n, rc;
        bus.CH_VALID = 1'b0;
        bus.CH_DATA  = 8'h00;
        bus.CH_COLOR = 12'h000;
        bus.CH_ATTR  = 2'b00;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(bus.CH_READY), 32'd0);
        chk("rst_we", 32'(bus.WRITE_EN), 32'd0);
        chk("rst_cursor", {bus.SCROLL_OFS, bus.CUR_ROW, bus.CUR_COL}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_ready_after", 32'(bus.CH_READY), 32'd1);

        // Single printable
        send(8'h41, 12'hF00, 2'b00, n);
        wait_ready(rc);
        chk("A_ready_cyc", 32'(rc), 32'(n + 2));
        chk("A_nwr", 32'(q_addr.size()), 32'd1);
        chk("A_addr", qa(0), 32'h0000);
        chk("A_data", qd(0), 32'h000F_0041);
        chk("A_be", qb(0), 32'h7);
        chk("A_wr_cyc", 32'(qc(0)), 32'(n + 1));
        chk("A_col", 32'(bus.CUR_COL), 32'd1);

        // Fill row 0 and wrap to row 1
        for (int i = 1; i < 80; i++) send(8'(8'h61 + i % 26), 12'h123, 2'b00, n);
        wait_ready(rc);
        chk("row0_last_addr", qa(0), 32'h013C);
        chk("row0_last_data", qd(0), 32'h0001_2362);
        chk("wrap_row", 32'(bus.CUR_ROW), 32'd1);
        chk("wrap_col", 32'(bus.CUR_COL), 32'd0);

        send(8'h42, 12'h5A3, 2'b10, n);
        wait_ready(rc);
        chk("B_addr", qa(0), 32'h0140);
        chk("B_data", qd(0), 32'h0025_A342);
        send(8'h7A, 12'h0F0, 2'b01, n);
        wait_ready(rc);
        chk("z_addr", qa(0), 32'h0144);
        chk("z_data", qd(0), 32'h0010_F07A);
        send(8'h7E, 12'h001, 2'b00, n);
        wait_ready(rc);
        chk("tilde_data", qd(0), 32'h0000_017E);
        send(8'h20, 12'h000, 2'b00, n);
        wait_ready(rc);
        chk("space_addr", qa(0), 32'h014C);

        // Non-printables and control codes
        send(8'h7F, 12'hFFF, 2'b11, n);  check_ctrl("del", n, 7'd4, 6'd1);
        send(8'h1F, 12'hFFF, 2'b11, n);  check_ctrl("x1f", n, 7'd4, 6'd1);
        send(8'hC1, 12'hFFF, 2'b11, n);  check_ctrl("xc1", n, 7'd4, 6'd1);
        send(8'h08, 12'h000, 2'b00, n);  check_ctrl("bs", n, 7'd3, 6'd1);
        send(8'h0D, 12'h000, 2'b00, n);  check_ctrl("cr", n, 7'd0, 6'd1);
        send(8'h08, 12'h000, 2'b00, n);  check_ctrl("bs_col0", n, 7'd0, 6'd1);
        send(8'h0A, 12'h000, 2'b00, n);  check_ctrl("lf", n, 7'd0, 6'd2);

        // Walk to last row, put 5 chars, then LF scroll
        for (int i = 0; i < 47; i++) send(8'h0A, 12'h000, 2'b00, n);
        for (int i = 0; i < 5; i++) send(8'h30, 12'h000, 2'b00, n);
        wait_ready(rc);
        chk("row49_addr", qa(0), 32'h3D50);
        send(8'h0A, 12'h000, 2'b00, n);
        wait_ready(rc);
        chk("lfs_ready_cyc", 32'(rc), 32'(n + 82));
        chk("lfs_nwr", 32'(q_addr.size()), 32'd81);
        chk("lfs_conf", {qa(0)[15:0], qd(0)[7:0], qb(0)[3:0], 4'h0}, {16'h4000, 8'h01, 4'h1, 4'h0});
        chk("lfs_conf_cyc", 32'(qc(0)), 32'(n + 1));
        check_clear_run("lfs_clear_run", 1, 80, 16'h0000, n + 2);
        chk("lfs_state", {bus.SCROLL_OFS, bus.CUR_ROW, bus.CUR_COL}, {13'd0, 6'd1, 6'd49, 7'd0});

        // Wrap-scroll from the last column of the last row
        for (int i = 0; i < 79; i++) send(8'h78, 12'h000, 2'b00, n);
        send(8'h57, 12'hABC, 2'b11, n);
        wait_ready(rc);
        chk("ws_ready_cyc", 32'(rc), 32'(n + 83));
        chk("ws_nwr", 32'(q_addr.size()), 32'd82);
        chk("ws_char_addr", qa(0), 32'h013C);
        chk("ws_char_data", qd(0), 32'h003A_BC57);
        chk("ws_conf", {qa(1)[15:0], qd(1)[7:0], qb(1)[3:0], 4'h0}, {16'h4000, 8'h02, 4'h1, 4'h0});
        chk("ws_conf_cyc", 32'(qc(1)), 32'(n + 2));
        check_clear_run("ws_clear_run", 2, 80, 16'h0140, n + 3);
        chk("ws_state", {bus.SCROLL_OFS, bus.CUR_ROW, bus.CUR_COL}, {13'd0, 6'd2, 6'd49, 7'd0});

        // Offset 49: physical row wraps, then offset wraps to 0
        for (int i = 0; i < 47; i++) send(8'h0A, 12'h000, 2'b00, n);
        chk("ofs49", 32'(bus.SCROLL_OFS), 32'd49);
        send(8'h42, 12'h5A3, 2'b10, n);
        wait_ready(rc);
        chk("prow_wrap_addr", qa(0), 32'h3C00);
        send(8'h0A, 12'h000, 2'b00, n);
        wait_ready(rc);
        chk("ofs_wrap_conf", qd(0), 32'h0);
        check_clear_run("ofs_wrap_clear", 1, 80, 16'h3D40, n + 2);
        chk("ofs_wrap_ofs", 32'(bus.SCROLL_OFS), 32'd0);

        // Form feed
        send(8'h0C, 12'h000, 2'b00, n);
        wait_ready(rc);
        chk("ff_ready_cyc", 32'(rc), 32'(n + 4002));
        chk("ff_nwr", 32'(q_addr.size()), 32'd4001);
        check_clear_run("ff_clear_run", 0, 4000, 16'h0000, n + 1);
        chk("ff_conf", {qa(4000)[15:0], qd(4000)[7:0], qb(4000)[3:0], 4'h0}, {16'h4000, 8'h00, 4'h1, 4'h0});
        chk("ff_conf_cyc", 32'(qc(4000)), 32'(n + 4001));
        chk("ff_state", {bus.SCROLL_OFS, bus.CUR_ROW, bus.CUR_COL}, 32'd0);
        send(8'h08, 12'h000, 2'b00, n);  check_ctrl("ff_bs_col0", n, 7'd0, 6'd0);

        // Reset in the middle of a full clear
        send(8'h41, 12'h000, 2'b00, n);
        send(8'h0C, 12'h000, 2'b00, n);
        repeat (100) @(negedge CLK);
        chk("mid_ff_active", 32'(bus.WRITE_EN), 32'd1);
        RST = 1'b0;
        #1;
        chk("mid_rst_we", 32'(bus.WRITE_EN), 32'd0);
        chk("mid_rst_bus", {bus.WRITE_ADDR, bus.BYTE_EN, 12'd0} | bus.WRITE_DATA, 32'd0);
        chk("mid_rst_ready", 32'(bus.CH_READY), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        clear_q();
        repeat (50) @(negedge CLK);
        chk("post_rst_nwr", 32'(q_addr.size()), 32'd0);
        send(8'h41, 12'hF00, 2'b00, n);
        wait_ready(rc);
        chk("post_rst_addr", qa(0), 32'h0000);
        chk("post_rst_data", qd(0), 32'h000F_0041);

        chk("idle_bus_zero", 32'(idle_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire
